add_accumulator: RTL and testbench
==================================

ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 Parameter ACC_W, default 8: accumulator width in bits.
REQ-002 Parameter CNT_W, default 4: width of the add counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 sum_in  input  4  sum bits from the upstream 4-bit adder.
REQ-006 cout_in  input  1  carry-out from the upstream adder; operand = {cout_in, sum_in}, range 0..31.
REQ-007 add_req  input  1  asynchronous level from a pushbutton; each rising edge requests one accumulate.
REQ-008 clr  input  1  synchronous clear of accumulator, flag and counter.
REQ-009 acc_out  output  ACC_W  running total.
REQ-010 ovf  output  1  sticky overflow flag.
REQ-011 add_cnt  output  CNT_W  number of accumulates since the last clear, saturating.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 done  output  1  one-cycle pulse marking an accumulate.

Function
REQ-014 add_req shall pass through a two-flop synchronizer; a rising edge is detected when the synchronized level is 1 and its registered previous value is 0.
REQ-015 FSM states shall be IDLE, CAPTURE, ACCUM and WAIT_REL.
REQ-016 IDLE -> CAPTURE on a detected edge; otherwise IDLE holds.
REQ-017 CAPTURE shall register the zero-extended operand {cout_in, sum_in} into an internal register and go to ACCUM unconditionally.
REQ-018 ACCUM shall set acc_out <= acc_out + operand (mod 2^ACC_W), drive done for exactly one cycle, then go to WAIT_REL.
REQ-019 WAIT_REL shall return to IDLE once the synchronized add_req is 0; holding the button does not cause a repeat add.
REQ-020 Latency: for add_req first sampled high at edge k, the operand is captured at edge k+3, acc_out updates at edge k+4, and done is high for the cycle after edge k+4.
REQ-021 A carry out of bit ACC_W-1 during an add shall set ovf, which stays set until clr or reset.
REQ-022 add_cnt shall increment on every add and saturate at 2^CNT_W-1.
REQ-023 clr shall zero acc_out, ovf and add_cnt, and force the FSM to IDLE on the same edge.
REQ-024 If clr is asserted in the same cycle as an edge detection or an ACCUM, clr wins and that add is discarded.
REQ-025 A clr issued mid-operation while the button is still held shall not cause a new add until a fresh rising edge occurs (the edge-detect history register is not cleared by clr).
REQ-026 sum_in and cout_in are sampled only in CAPTURE; changes at any other time have no effect.

Reset
REQ-027 While reset is high at a clock edge: FSM = IDLE, acc_out = 0, ovf = 0, add_cnt = 0, done = 0, busy = 0, and synchronizer and edge-history flops = 0.
REQ-028 reset shall take priority over clr and over all FSM activity, including reset asserted mid-operation.

Structure
REQ-029 A shared package shall hold the FSM state enum, ACC_W and CNT_W defaults, and the operand width constant OPER_W = 5.
REQ-030 The synchronizer and edge detector shall be one sub-module, sync_edge (inputs clk, reset, async_in; outputs level, rise).
REQ-031 All outputs shall be registered; no combinational path shall run from any input to any output.

Verification
REQ-032 After reset, sum_in=4'hF, cout_in=1, one press: acc_out=31, add_cnt=1, done high for exactly one cycle at edge k+4.
REQ-033 Nine presses of operand 31 from 0: acc_out=279 mod 256=23 after the ninth, ovf=1, and ovf remains 1 on a further press of operand 0.
REQ-034 Button held high for 50 cycles: exactly one add, busy stays high until the synchronized level drops, then returns to IDLE.
REQ-035 Sixteen presses of operand 1: add_cnt saturates at 15, acc_out=16.
REQ-036 clr asserted in the ACCUM cycle with acc_out=10 and operand 5: next acc_out=0, add_cnt=0, no done pulse, FSM in IDLE.
REQ-037 reset pulsed for one cycle during WAIT_REL with acc_out=200 and ovf=1: all outputs 0, and a held button gives no add until it is released and pressed again.

Source files
------------

// File: rtl/add_accumulator_pkg.sv
// Shared definitions for the pushbutton-driven add accumulator:
// FSM state encoding, default widths and the adder operand width.
package add_accumulator_pkg;

  localparam int ACC_W_DEF = 8;
  localparam int CNT_W_DEF = 4;
  localparam int OPER_W    = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    ACCUM    = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for an asynchronous
// pushbutton level.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic       meta;
  logic       prev;
  logic [1:0] fill;
  logic       armed;

  // Edges are only honoured once a released (low) level has been seen after
  // reset, so a button still held through reset cannot trigger an add.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
      fill  <= 2'd0;
      armed <= 1'b0;
    end else begin
      meta  <= async_in;
      level <= meta;
      prev  <= level;
      if (fill != 2'd2) begin
        fill <= fill + 2'd1;
      end
      if (fill == 2'd2 && !level) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = level & ~prev & armed;

endmodule

// File: rtl/add_accumulator.sv
// Accumulates the upstream 4-bit adder result {cout_in, sum_in} once per
// button press, with sticky overflow and a saturating press counter.
module add_accumulator
  import add_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       sum_in,
  input  logic             cout_in,
  input  logic             add_req,
  input  logic             clr,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic [CNT_W-1:0] add_cnt,
  output logic             busy,
  output logic             done
);

  state_t            state;
  state_t            next_state;
  logic              req_level;
  logic              req_rise;
  logic [OPER_W-1:0] oper_q;
  logic [ACC_W:0]    sum_ext;

  sync_edge u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .async_in (add_req),
    .level    (req_level),
    .rise     (req_rise)
  );

  assign sum_ext = {1'b0, acc_out} + {{(ACC_W + 1 - OPER_W){1'b0}}, oper_q};

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (req_rise) next_state = CAPTURE;
      CAPTURE:  next_state = ACCUM;
      ACCUM:    next_state = WAIT_REL;
      WAIT_REL: if (!req_level) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (clr) begin
      next_state = IDLE;
    end
  end

  // busy is registered from next_state so it tracks the state register exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      oper_q  <= '0;
      acc_out <= '0;
      ovf     <= 1'b0;
      add_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      done  <= 1'b0;
      if (state == CAPTURE) begin
        oper_q <= {cout_in, sum_in};
      end
      if (clr) begin
        acc_out <= '0;
        ovf     <= 1'b0;
        add_cnt <= '0;
      end else if (state == ACCUM) begin
        acc_out <= sum_ext[ACC_W-1:0];
        done    <= 1'b1;
        if (sum_ext[ACC_W]) begin
          ovf <= 1'b1;
        end
        if (add_cnt != {CNT_W{1'b1}}) begin
          add_cnt <= add_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_add_accumulator.sv
// Directed, table-driven bench for add_accumulator: press latency, overflow,
// saturation, held button, clear during accumulate and reset mid-operation.
module tb_add_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sum_in;
  logic       cout_in;
  logic       add_req;
  logic       clr;
  logic [7:0] acc_out;
  logic       ovf;
  logic [3:0] add_cnt;
  logic       busy;
  logic       done;

  int vec_count  = 0;
  int miss_count = 0;

  typedef struct {
    logic [3:0] sum;
    logic       cout;
    int         exp_acc;
    int         exp_ovf;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[10];

  add_accumulator #(.ACC_W(8), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .sum_in  (sum_in),
    .cout_in (cout_in),
    .add_req (add_req),
    .clr     (clr),
    .acc_out (acc_out),
    .ovf     (ovf),
    .add_cnt (add_cnt),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete press: edge k is the first edge that samples add_req high.
  task automatic applyStimulus(input logic [3:0] s, input logic c, input int exp_acc);
    tick();
    sum_in  = s;
    cout_in = c;
    add_req = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("busy_capture", busy, 1);
    tick();
    checkOutput("done_early", done, 0);
    sum_in  = ~s;
    cout_in = ~c;
    tick();
    checkOutput("done_pulse", done, 1);
    checkOutput("acc_update", acc_out, exp_acc);
    add_req = 1'b0;
    tick();
    checkOutput("done_width", done, 0);
    for (int i = 0; i < 10 && busy; i++) tick();
    checkOutput("return_idle", busy, 0);
    tick();
  endtask

  task automatic pulseClr();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("clr_acc", acc_out, 0);
    checkOutput("clr_ovf", ovf, 0);
    checkOutput("clr_cnt", add_cnt, 0);
  endtask

  initial begin
    int dcount;
    int busy_low;
    int busy_high;

    vecs[0] = '{4'hF, 1'b1,  31, 0,  1};
    vecs[1] = '{4'hF, 1'b1,  62, 0,  2};
    vecs[2] = '{4'hF, 1'b1,  93, 0,  3};
    vecs[3] = '{4'hF, 1'b1, 124, 0,  4};
    vecs[4] = '{4'hF, 1'b1, 155, 0,  5};
    vecs[5] = '{4'hF, 1'b1, 186, 0,  6};
    vecs[6] = '{4'hF, 1'b1, 217, 0,  7};
    vecs[7] = '{4'hF, 1'b1, 248, 0,  8};
    vecs[8] = '{4'hF, 1'b1,  23, 1,  9};
    vecs[9] = '{4'h0, 1'b0,  23, 1, 10};

    reset   = 1'b1;
    clr     = 1'b0;
    add_req = 1'b0;
    sum_in  = 4'h0;
    cout_in = 1'b0;
    repeat (3) tick();
    checkOutput("reset_acc", acc_out, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_cnt", add_cnt, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    reset = 1'b0;
    repeat (5) tick();

    $display("[TB] single press, then overflow table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].sum, vecs[i].cout, vecs[i].exp_acc);
      checkOutput("table_acc", acc_out, vecs[i].exp_acc);
      checkOutput("table_ovf", ovf, vecs[i].exp_ovf);
      checkOutput("table_cnt", add_cnt, vecs[i].exp_cnt);
    end

    $display("[TB] button held for 50 cycles");
    pulseClr();
    tick();
    sum_in  = 4'h3;
    cout_in = 1'b0;
    add_req = 1'b1;
    dcount   = 0;
    busy_low = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (done) dcount++;
      if (i >= 3 && !busy) busy_low++;
    end
    checkOutput("hold_single_add", dcount, 1);
    checkOutput("hold_busy_low_cycles", busy_low, 0);
    add_req = 1'b0;
    tick();
    checkOutput("hold_busy_e1", busy, 1);
    tick();
    checkOutput("hold_busy_e2", busy, 1);
    tick();
    checkOutput("hold_idle_e3", busy, 0);
    checkOutput("hold_acc", acc_out, 3);
    checkOutput("hold_cnt", add_cnt, 1);

    $display("[TB] counter saturation");
    pulseClr();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'h1, 1'b0, i + 1);
      if (i == 14) checkOutput("sat_cnt_15", add_cnt, 15);
    end
    checkOutput("sat_cnt_final", add_cnt, 15);
    checkOutput("sat_acc_final", acc_out, 16);

    $display("[TB] clr during accumulate");
    pulseClr();
    applyStimulus(4'hA, 1'b0, 10);
    tick();
    sum_in  = 4'h5;
    cout_in = 1'b0;
    add_req = 1'b1;
    repeat (4) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checkOutput("accclr_acc", acc_out, 0);
    checkOutput("accclr_cnt", add_cnt, 0);
    checkOutput("accclr_done", done, 0);
    checkOutput("accclr_busy", busy, 0);
    dcount    = 0;
    busy_high = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) dcount++;
      if (busy) busy_high++;
    end
    checkOutput("accclr_held_no_add", dcount, 0);
    checkOutput("accclr_held_idle", busy_high, 0);
    add_req = 1'b0;
    repeat (5) tick();
    checkOutput("accclr_acc_after", acc_out, 0);

    $display("[TB] reset during wait-for-release");
    pulseClr();
    for (int i = 0; i < 14; i++) applyStimulus(4'hF, 1'b1, (31 * (i + 1)) % 256);
    applyStimulus(4'h6, 1'b1, 200);
    checkOutput("pre_reset_acc", acc_out, 200);
    checkOutput("pre_reset_ovf", ovf, 1);
    tick();
    sum_in  = 4'h0;
    cout_in = 1'b0;
    add_req = 1'b1;
    repeat (6) tick();
    checkOutput("pre_reset_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_acc", acc_out, 0);
    checkOutput("midrst_ovf", ovf, 0);
    checkOutput("midrst_cnt", add_cnt, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    dcount    = 0;
    busy_high = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dcount++;
      if (busy) busy_high++;
    end
    checkOutput("midrst_held_no_add", dcount, 0);
    checkOutput("midrst_held_idle", busy_high, 0);
    add_req = 1'b0;
    repeat (6) tick();
    applyStimulus(4'h7, 1'b0, 7);
    checkOutput("midrst_repress_cnt", add_cnt, 1);
    checkOutput("midrst_repress_ovf", ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
